// File: rtl/drops_pkg.sv
// drops_pkg: definitions shared by the game-logic stages.
//   GS_DEF       default grid size (matrix is GS_DEF x GS_DEF)
//   scan_st_e    led_scan frame FSM states
//   HS_*         4-phase enable/done handshake phases seen by the sequencer
//   max_int      small helper for counter sizing
package drops_pkg;

    localparam int GS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2,
        ST_DONE  = 2'd3
    } scan_st_e;

    // Sequencer view of one enable/done exchange with a stage.
    localparam logic [1:0] HS_IDLE = 2'd0;  // e=0, d=0
    localparam logic [1:0] HS_REQ  = 2'd1;  // e=1, d=0 (stage working)
    localparam logic [1:0] HS_ACK  = 2'd2;  // e=1, d=1 (stage finished)
    localparam logic [1:0] HS_REL  = 2'd3;  // e=0, d=1 (stage returning idle)

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// scan_timer: loadable down-counter shared by the dwell and blank phases.
//   clk_i, rst_i   clock / synchronous active-high reset
//   load_i         load load_val_i this edge (takes priority over counting)
//   load_val_i     value to load; phase length minus one
//   tc_o           terminal count: high while the count is zero, which marks
//                  the last cycle of the current phase
module scan_timer #(
    parameter int CW = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/led_scan.sv
// led_scan: drives the LED matrix one row at a time from a snapshot of the
// drop matrix, under a 4-phase enable/done handshake with the sequencer.
//   clk_i, rst_i   clock / synchronous active-high reset
//   e_scan_i       scan request, held until d_scan_o is seen
//   matrix_i       GS*GS pixels, bit r*GS+c = row r, column c
//   row_val_o      one-hot active row (0 while blanking / idle / done)
//   col_val_o      column data of the active row
//   d_scan_o       frame done, high while in DONE
//   busy_o         high while showing or blanking
module led_scan
    import drops_pkg::*;
#(
    parameter int GS    = GS_DEF,
    parameter int DWELL = 4,
    parameter int BLANK = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            e_scan_i,
    input  logic [GS*GS-1:0] matrix_i,
    output logic [GS-1:0]   row_val_o,
    output logic [GS-1:0]   col_val_o,
    output logic            d_scan_o,
    output logic            busy_o
);

    if (DWELL < 1) begin : g_bad_dwell
        $error("led_scan: DWELL must be >= 1");
    end
    if (BLANK < 0) begin : g_bad_blank
        $error("led_scan: BLANK must be >= 0");
    end
    if (GS < 2) begin : g_bad_gs
        $error("led_scan: GS must be >= 2");
    end

    localparam int RW = $clog2(GS);
    localparam int CW = $clog2(max_int(DWELL, BLANK) + 1);
    localparam logic [CW-1:0] DW_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BL_LD = CW'((BLANK > 0) ? BLANK - 1 : 0);

    scan_st_e         state_q, state_d;
    logic [GS*GS-1:0] frame_q, frame_d;
    logic [RW-1:0]    row_q, row_d;
    logic [GS-1:0]    sel_q, sel_d;      // one-hot twin of row_q
    logic [GS-1:0]    row_val_q, row_val_d;
    logic [GS-1:0]    col_val_q, col_val_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             tm_load;
    logic [CW-1:0]    tm_val;
    logic             tm_tc;

    logic             last_row;
    logic [RW-1:0]    row_nxt;

    scan_timer #(.CW(CW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tm_load),
        .load_val_i (tm_val),
        .tc_o       (tm_tc)
    );

    assign last_row = (row_q == RW'(GS - 1));
    assign row_nxt  = row_q + RW'(1);

    // Next-state and next-output logic. Outputs are computed for the state
    // being entered so the registered values line up with the state.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        row_d     = row_q;
        sel_d     = sel_q;
        row_val_d = '0;
        col_val_d = '0;
        done_d    = 1'b0;
        busy_d    = 1'b0;
        tm_load   = 1'b0;
        tm_val    = DW_LD;

        unique case (state_q)
            ST_IDLE: begin
                if (e_scan_i) begin
                    frame_d   = matrix_i;
                    row_d     = '0;
                    sel_d     = GS'(1);
                    tm_load   = 1'b1;
                    tm_val    = DW_LD;
                    state_d   = ST_SHOW;
                    row_val_d = GS'(1);
                    col_val_d = matrix_i[GS-1:0];
                    busy_d    = 1'b1;
                end
            end

            ST_SHOW: begin
                busy_d = 1'b1;
                if (!tm_tc) begin
                    row_val_d = sel_q;
                    col_val_d = frame_q[int'(row_q)*GS +: GS];
                end else if (BLANK > 0) begin
                    tm_load = 1'b1;
                    tm_val  = BL_LD;
                    state_d = ST_BLANK;
                end else if (last_row) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    row_d     = row_nxt;
                    sel_d     = sel_q << 1;
                    tm_load   = 1'b1;
                    tm_val    = DW_LD;
                    row_val_d = sel_q << 1;
                    col_val_d = frame_q[int'(row_nxt)*GS +: GS];
                end
            end

            ST_BLANK: begin
                busy_d = 1'b1;
                if (tm_tc) begin
                    if (last_row) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d   = ST_SHOW;
                        row_d     = row_nxt;
                        sel_d     = sel_q << 1;
                        tm_load   = 1'b1;
                        tm_val    = DW_LD;
                        row_val_d = sel_q << 1;
                        col_val_d = frame_q[int'(row_nxt)*GS +: GS];
                    end
                end
            end

            ST_DONE: begin
                // Leave only once the request has been withdrawn.
                if (e_scan_i) done_d  = 1'b1;
                else          state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            row_q     <= '0;
            sel_q     <= '0;
            row_val_q <= '0;
            col_val_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            row_q     <= row_d;
            sel_q     <= sel_d;
            row_val_q <= row_val_d;
            col_val_q <= col_val_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign row_val_o = row_val_q;
    assign col_val_o = col_val_q;
    assign d_scan_o  = done_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_led_scan.sv
module tb_led_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        ea, eb;
    logic [63:0] matrix;
    logic [7:0]  row_a, col_a, row_b, col_b;
    logic        done_a, busy_a, done_b, busy_b;
    logic        sel;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Default build: DWELL=4, BLANK=1.
    led_scan #(.GS(8), .DWELL(4), .BLANK(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .e_scan_i(ea), .matrix_i(matrix),
        .row_val_o(row_a), .col_val_o(col_a), .d_scan_o(done_a), .busy_o(busy_a)
    );

    // Fast build: DWELL=1, no blanking.
    led_scan #(.GS(8), .DWELL(1), .BLANK(0)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .e_scan_i(eb), .matrix_i(matrix),
        .row_val_o(row_b), .col_val_o(col_b), .d_scan_o(done_b), .busy_o(busy_b)
    );

    logic [7:0] o_row, o_col;
    logic       o_done, o_busy;
    assign o_row  = sel ? row_b  : row_a;
    assign o_col  = sel ? col_b  : col_a;
    assign o_done = sel ? done_b : done_a;
    assign o_busy = sel ? busy_b : busy_a;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " row"},  64'(o_row),  64'h0);
        chk({tag, " col"},  64'(o_col),  64'h0);
        chk({tag, " done"}, 64'(o_done), 64'h0);
        chk({tag, " busy"}, 64'(o_busy), 64'h0);
    endtask

    // One frame on DUT s. Reference: frame period P=DWELL+BLANK per row; at
    // t cycles after capture, row t/P is lit when t%P < DWELL, showing the
    // snapshot byte; d_scan_o rises at t = 8*P.
    task automatic run_frame(input bit s, input logic [63:0] m, input int drop_t,
                             input int zap_t, input logic [63:0] zap_v, input int hold);
        int d, b, p, len, r;
        logic [7:0] er, ec;
        d   = s ? 1 : 4;
        b   = s ? 0 : 1;
        p   = d + b;
        len = 8 * p;
        @(negedge clk);
        sel    = s;
        matrix = m;
        if (s) eb = 1'b1; else ea = 1'b1;
        @(posedge clk); #1;
        for (int t = 0; t < len; t++) begin
            r  = t / p;
            er = 8'h0;
            ec = 8'h0;
            if ((t % p) < d) begin
                er = 8'h1 << r;
                ec = m[r*8 +: 8];
            end
            chk($sformatf("row t=%0d", t),  64'(o_row),  64'(er));
            chk($sformatf("col t=%0d", t),  64'(o_col),  64'(ec));
            chk($sformatf("busy t=%0d", t), 64'(o_busy), 64'h1);
            chk($sformatf("done t=%0d", t), 64'(o_done), 64'h0);
            @(negedge clk);
            if (t == drop_t) begin ea = 1'b0; eb = 1'b0; end
            if (t == zap_t) matrix = zap_v;
            @(posedge clk); #1;
        end
        chk("done rise", 64'(o_done), 64'h1);
        chk("done row",  64'(o_row),  64'h0);
        chk("done col",  64'(o_col),  64'h0);
        chk("done busy", 64'(o_busy), 64'h0);
        if (drop_t < len) begin
            @(posedge clk); #1;
            chk("done one cycle", 64'(o_done), 64'h0);
        end else begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk($sformatf("hold done h=%0d", h), 64'(o_done), 64'h1);
                chk($sformatf("hold row h=%0d", h),  64'(o_row),  64'h0);
                chk($sformatf("hold busy h=%0d", h), 64'(o_busy), 64'h0);
            end
            @(negedge clk);
            ea = 1'b0; eb = 1'b0;
            @(posedge clk); #1;
            chk("release done", 64'(o_done), 64'h0);
        end
        @(posedge clk); #1;
        chk_quiet("idle after frame");
    endtask

    initial begin
        rst = 1'b1; ea = 1'b0; eb = 1'b0; matrix = '0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset a");
        sel = 1'b1; #0;
        chk_quiet("reset b");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Single pixel at row 1, column 2.
        run_frame(1'b0, 64'h1 << 10, 1000, 1000, '0, 0);
        // Fixed drop pattern.
        run_frame(1'b0, 64'h1001_8020_0208_8004, 1000, 1000, '0, 2);
        // Snapshot: input cleared from cycle 3 on.
        run_frame(1'b0, {64{1'b1}}, 1000, 2, '0, 1);
        // Handshake: hold request through DONE, then a fresh frame.
        run_frame(1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 1000, 1000, '0, 10);
        run_frame(1'b0, 64'h0123_4567_89AB_CDEF, 1000, 1000, '0, 0);
        // Request dropped mid-scan: DONE lasts a single cycle.
        run_frame(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 12, 1000, '0, 0);
        // No-blank build.
        run_frame(1'b1, 64'h1001_8020_0208_8004, 1000, 1000, '0, 3);
        run_frame(1'b1, 64'hFFFF_0000_FFFF_0000, 1000, 4, 64'h5555_5555_5555_5555, 0);

        // Reset mid-scan aborts; no done afterwards.
        @(negedge clk);
        sel = 1'b0; matrix = {64{1'b1}}; ea = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; ea = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_quiet($sformatf("in reset k=%0d", k));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            chk_quiet($sformatf("after reset k=%0d", k));
        end

        // Randomised frames.
        for (int i = 0; i < 8; i++) begin
            bit          s;
            logic [63:0] m, zv;
            int          dt, zt, hd;
            s  = 1'($urandom_range(0, 1));
            m  = {$urandom, $urandom};
            zv = {$urandom, $urandom};
            dt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 39)) : 1000;
            if (s && dt != 1000) dt = dt % 8;
            zt = int'($urandom_range(0, 7));
            hd = int'($urandom_range(0, 5));
            run_frame(s, m, dt, zt, zv, hd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
